// File: rtl/display_bcm_pkg.sv
// Shared types and helpers for the BCM scan sequencer.
// The pulse_len() result width assumes the default BITWIDTH/BASE_W.
package display_bcm_pkg;

    localparam int BCM_BITWIDTH = 8;
    localparam int BCM_ROWS     = 16;
    localparam int BCM_BASE_W   = 8;
    localparam int SEL_W        = $clog2(BCM_BITWIDTH);
    localparam int ROW_W        = $clog2(BCM_ROWS);
    localparam int PULSE_W      = BCM_BASE_W + BCM_BITWIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BLANK,
        ST_SHOW,
        ST_WAIT
    } bcm_state_e;

    // Weighted plane length: (base + 1) << bit, never zero
    function automatic logic [PULSE_W-1:0] pulse_len(
        input logic [PULSE_W-1:0] base,
        input logic [7:0]         b
    );
        return (base + PULSE_W'(1)) << b;
    endfunction

endpackage

// File: rtl/display_bcm_pulse_timer.sv
// Loadable down-counter timing both BLANK and SHOW intervals.
// o_last flags the final cycle of a loaded interval; o_remain counts down to 0.
module display_bcm_pulse_timer
    import display_bcm_pkg::*;
#(
    parameter int W = PULSE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_len,
    output logic         o_last,
    output logic [W-1:0] o_remain
);

    logic [W-1:0] r_cnt;
    logic         r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_load) begin
            r_cnt  <= i_len - W'(1);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt == '0)
                r_busy <= 1'b0;
            else
                r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_last   = r_busy && (r_cnt == '0);
    assign o_remain = r_cnt;

endmodule

// File: rtl/display_bcm_scan_sequencer.sv
// BCM row/bit-plane scan sequencer driving panel OE/LAT/address.
// Define DISPLAY_BCM_DIM_EN to add the i_dim brightness input.
module display_bcm_scan_sequencer
    import display_bcm_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int ROWS     = 16,
    parameter int BASE_W   = 8,
    parameter int DEADTIME = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_enable,
    input  logic [BASE_W-1:0]           i_base_len,
`ifdef DISPLAY_BCM_DIM_EN
    input  logic [2:0]                  i_dim,
`endif
    output logic                        o_load_req,
    input  logic                        i_load_ack,
    output logic [$clog2(ROWS)-1:0]     o_req_row,
    output logic [$clog2(BITWIDTH)-1:0] o_req_bit,
    output logic                        o_latch,
    output logic                        o_oe,
    output logic [$clog2(ROWS)-1:0]     o_row,
    output logic [$clog2(BITWIDTH)-1:0] o_select,
    output logic                        o_plane_done,
    output logic                        o_frame_done
);

    localparam int RW = $clog2(ROWS);
    localparam int SW = $clog2(BITWIDTH);
    localparam int LW = BASE_W + BITWIDTH;

    bcm_state_e        r_state;
    logic [BASE_W-1:0] r_base;
    logic [RW-1:0]     r_row;
    logic [RW-1:0]     r_req_row;
    logic [SW-1:0]     r_select;
    logic [SW-1:0]     r_req_bit;
    logic              r_load_req;
    logic              r_latch;
    logic              r_oe;
    logic              r_plane_done;
    logic              r_frame_done;
    logic              r_ack_flag;

    logic              w_ack;
    logic              w_last_plane;
    logic              w_to_blank;
    logic              w_to_show;
    logic              w_start;
    logic              w_tmr_load;
    logic              w_tmr_last;
    logic              w_last_next;
    logic [LW-1:0]     w_show_len;
    logic [LW-1:0]     w_on_len;
    logic [LW-1:0]     w_tmr_len;
    logic [LW-1:0]     w_tmr_remain;
    logic [RW-1:0]     w_next_row;
    logic [SW-1:0]     w_next_bit;

    assign w_ack        = i_load_ack & r_load_req;
    assign w_last_plane = (r_row == RW'(ROWS - 1)) && (r_select == '0);
    assign w_next_row   = (r_select == '0) ? r_row + RW'(1) : r_row;
    assign w_next_bit   = (r_select == '0) ? SW'(BITWIDTH - 1)
                                           : r_select - SW'(1);
    assign w_show_len   = LW'(pulse_len(PULSE_W'(r_base), 8'(r_select)));

`ifdef DISPLAY_BCM_DIM_EN
    logic [2:0]    r_dim;
    logic [LW-1:0] w_dim_len;

    assign w_dim_len = w_show_len >> r_dim;
    assign w_on_len  = (w_dim_len == '0) ? LW'(1) : w_dim_len;
`else
    assign w_on_len  = w_show_len;
`endif

    assign w_to_blank = (w_ack && (r_state == ST_LOAD || r_state == ST_WAIT))
                     || (r_state == ST_SHOW && w_tmr_last && !w_last_plane
                         && (r_ack_flag || w_ack));
    assign w_to_show  = (r_state == ST_BLANK) && w_tmr_last;
    assign w_start    = i_enable && ((r_state == ST_IDLE)
                     || (r_state == ST_SHOW && w_tmr_last && w_last_plane));
    assign w_tmr_load = w_to_blank || w_to_show;
    assign w_tmr_len  = w_to_show ? w_show_len : LW'(DEADTIME);

    // Registered done pulses must be predicted one cycle early
    assign w_last_next = (w_to_show && w_show_len == LW'(1))
                      || (r_state == ST_SHOW && w_tmr_remain == LW'(1));

    display_bcm_pulse_timer #(.W(LW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_tmr_load),
        .i_len    (w_tmr_len),
        .o_last   (w_tmr_last),
        .o_remain (w_tmr_remain)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base <= '0;
        end else if (w_start) begin
            r_base <= i_base_len;
        end
    end

`ifdef DISPLAY_BCM_DIM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dim <= '0;
        end else if (w_start) begin
            r_dim <= i_dim;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_row        <= '0;
            r_select     <= '0;
            r_req_row    <= '0;
            r_req_bit    <= '0;
            r_load_req   <= 1'b0;
            r_latch      <= 1'b0;
            r_oe         <= 1'b0;
            r_plane_done <= 1'b0;
            r_frame_done <= 1'b0;
            r_ack_flag   <= 1'b0;
        end else begin
            r_latch      <= 1'b0;
            r_plane_done <= w_last_next;
            r_frame_done <= w_last_next && w_last_plane;
            if (w_to_blank) begin
                r_state    <= ST_BLANK;
                r_latch    <= 1'b1;
                r_load_req <= 1'b0;
                r_row      <= r_req_row;
                r_select   <= r_req_bit;
                r_oe       <= 1'b0;
            end else if (w_start) begin
                r_state    <= ST_LOAD;
                r_load_req <= 1'b1;
                r_req_row  <= '0;
                r_req_bit  <= SW'(BITWIDTH - 1);
                r_oe       <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_BLANK: begin
                        if (w_tmr_last) begin
                            r_state    <= ST_SHOW;
                            r_oe       <= 1'b1;
                            r_ack_flag <= 1'b0;
                            if (!w_last_plane) begin
                                r_load_req <= 1'b1;
                                r_req_row  <= w_next_row;
                                r_req_bit  <= w_next_bit;
                            end
                        end
                    end
                    ST_SHOW: begin
                        if (w_ack) begin
                            r_ack_flag <= 1'b1;
                            r_load_req <= 1'b0;
                        end
                        if (w_tmr_last) begin
                            r_oe    <= 1'b0;
                            r_state <= w_last_plane ? ST_IDLE : ST_WAIT;
                        end else begin
                            r_oe <= (w_show_len - w_tmr_remain) < w_on_len;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_load_req   = r_load_req;
    assign o_req_row    = r_req_row;
    assign o_req_bit    = r_req_bit;
    assign o_latch      = r_latch;
    assign o_oe         = r_oe;
    assign o_row        = r_row;
    assign o_select     = r_select;
    assign o_plane_done = r_plane_done;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_display_bcm_scan_sequencer.sv
// Directed bench for display_bcm_scan_sequencer (BITWIDTH=4, ROWS=2, DEADTIME=2).
// Build with DISPLAY_BCM_DIM_EN defined to also exercise the dim input.
module tb_display_bcm_scan_sequencer;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] base_len;
    logic [2:0] dim;
    logic       load_ack;
    logic       load_req;
    logic       req_row;
    logic [1:0] req_bit;
    logic       latch;
    logic       oe;
    logic       row;
    logic [1:0] select;
    logic       plane_done;
    logic       frame_done;

    int n_tests;
    int n_fail;

    int run_len[16];
    int n_runs, n_oe, n_latch, n_pd, n_fd, n_cyc, n_mis;
    bit timed_out;

    display_bcm_scan_sequencer #(
        .BITWIDTH (4),
        .ROWS     (2),
        .BASE_W   (8),
        .DEADTIME (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_enable     (enable),
        .i_base_len   (base_len),
`ifdef DISPLAY_BCM_DIM_EN
        .i_dim        (dim),
`endif
        .o_load_req   (load_req),
        .i_load_ack   (load_ack),
        .o_req_row    (req_row),
        .o_req_bit    (req_bit),
        .o_latch      (latch),
        .o_oe         (oe),
        .o_row        (row),
        .o_select     (select),
        .o_plane_done (plane_done),
        .o_frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Samples each cycle until frame_done; collects oe run lengths and counts
    task automatic measure_frame(input int budget, input int chg_cyc,
                                 input logic [7:0] chg_val);
        int cur;
        bit done;
        cur = 0;
        done = 0;
        n_runs = 0; n_oe = 0; n_latch = 0; n_pd = 0;
        n_fd = 0; n_cyc = 0; n_mis = 0; timed_out = 0;
        for (int i = 0; i < 16; i++) run_len[i] = 0;
        while (!done) begin
            @(negedge clk);
            n_cyc++;
            if (oe) begin
                cur++;
                n_oe++;
            end else if (cur > 0) begin
                if (n_runs < 16) run_len[n_runs] = cur;
                n_runs++;
                cur = 0;
            end
            if (latch) n_latch++;
            if (plane_done) n_pd++;
            if (frame_done && !plane_done) n_mis++;
            if (n_cyc == chg_cyc) base_len = chg_val;
            if (frame_done) begin
                n_fd++;
                if (cur > 0) begin
                    if (n_runs < 16) run_len[n_runs] = cur;
                    n_runs++;
                end
                done = 1;
            end else if (n_cyc >= budget) begin
                timed_out = 1;
                done = 1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({oe, load_req, latch} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: oe/req/latch=%b want 000",
                     {oe, load_req, latch});
        end
        n_tests++;
        if ({row, select, req_row, req_bit} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_addr: got %b want 0",
                     {row, select, req_row, req_bit});
        end
        n_tests++;
        if ({plane_done, frame_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_done: got %b want 00",
                     {plane_done, frame_done});
        end
        rst = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_basic_frame();
        base_len = 8'd0;
        load_ack = 1'b1;
        apply_reset();
        enable = 1'b1;
        measure_frame(500, -1, 8'd0);
        n_tests++;
        if (timed_out || n_fd != 1) begin
            n_fail++;
            $display("FAIL basic_frame_done: fd=%0d timeout=%0d want 1,0",
                     n_fd, timed_out);
        end
        n_tests++;
        if (n_runs != 8 || run_len[0] != 8 || run_len[1] != 4 ||
            run_len[2] != 2 || run_len[3] != 1 || run_len[4] != 8 ||
            run_len[7] != 1) begin
            n_fail++;
            $display("FAIL basic_runs: n=%0d r=%0d,%0d,%0d,%0d,%0d,%0d want 8:8,4,2,1,8,1",
                     n_runs, run_len[0], run_len[1], run_len[2],
                     run_len[3], run_len[4], run_len[7]);
        end
        n_tests++;
        if (n_oe != 30 || n_latch != 8) begin
            n_fail++;
            $display("FAIL basic_counts: oe=%0d latch=%0d want 30,8",
                     n_oe, n_latch);
        end
        n_tests++;
        if (n_pd != 8 || n_mis != 0) begin
            n_fail++;
            $display("FAIL basic_plane_done: pd=%0d mis=%0d want 8,0",
                     n_pd, n_mis);
        end
        n_tests++;
        if (n_cyc != 47) begin
            n_fail++;
            $display("FAIL basic_frame1_len: got %0d want 47", n_cyc);
        end
        measure_frame(500, -1, 8'd0);
        n_tests++;
        if (timed_out || n_cyc != 47 || n_oe != 30 || n_fd != 1) begin
            n_fail++;
            $display("FAIL basic_frame2: cyc=%0d oe=%0d fd=%0d want 47,30,1",
                     n_cyc, n_oe, n_fd);
        end
    endtask

    task automatic test_base_len();
        base_len = 8'd3;
        load_ack = 1'b1;
        apply_reset();
        enable = 1'b1;
        measure_frame(500, 5, 8'd0);
        n_tests++;
        if (timed_out || run_len[0] != 32 || run_len[3] != 4 ||
            run_len[4] != 32 || n_oe != 120) begin
            n_fail++;
            $display("FAIL base3_frame: r0=%0d r3=%0d r4=%0d oe=%0d want 32,4,32,120",
                     run_len[0], run_len[3], run_len[4], n_oe);
        end
        measure_frame(500, -1, 8'd0);
        n_tests++;
        if (timed_out || run_len[0] != 8 || run_len[3] != 1 || n_oe != 30) begin
            n_fail++;
            $display("FAIL base_next_frame: r0=%0d r3=%0d oe=%0d want 8,1,30",
                     run_len[0], run_len[3], n_oe);
        end
        enable = 1'b0;
    endtask

    task automatic test_ack_wait();
        int k;
        int show;
        int errs;
        base_len = 8'd0;
        load_ack = 1'b1;
        apply_reset();
        enable = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(oe && select == 2'd2) && k < 200);
        load_ack = 1'b0;
        show = 1;
        errs = 0;
        n_tests++;
        if (k >= 200) begin
            n_fail++;
            $display("FAIL wait_find_bit2: timeout after %0d cycles", k);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!oe) break;
            show++;
            if (!load_req) errs++;
        end
        n_tests++;
        if (show != 4 || errs != 0) begin
            n_fail++;
            $display("FAIL wait_bit2_show: len=%0d reqerr=%0d want 4,0",
                     show, errs);
        end
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            if (oe || !load_req || latch || req_bit != 2'd1) errs++;
        end
        load_ack = 1'b1;
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL wait_hold: bad cycles=%0d want 0", errs);
        end
        @(negedge clk);
        n_tests++;
        if (latch !== 1'b1 || oe !== 1'b0 || select !== 2'd1 ||
            row !== 1'b0 || load_req !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_blank1: latch=%b oe=%b sel=%0d row=%0d req=%b want 1,0,1,0,0",
                     latch, oe, select, row, load_req);
        end
        @(negedge clk);
        n_tests++;
        if (latch !== 1'b0 || oe !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_blank2: latch=%b oe=%b want 0,0", latch, oe);
        end
        show = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(oe && select == 2'd1)) break;
            show++;
        end
        n_tests++;
        if (show != 2) begin
            n_fail++;
            $display("FAIL wait_bit1_show: got %0d want 2", show);
        end
        enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        int k;
        int errs;
        base_len = 8'd0;
        load_ack = 1'b1;
        apply_reset();
        enable = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(oe && select == 2'd3 && row == 1'b0) && k < 200);
        enable = 1'b0;
        measure_frame(500, -1, 8'd0);
        n_tests++;
        if (timed_out || n_fd != 1 || n_latch != 7 || n_pd != 8) begin
            n_fail++;
            $display("FAIL drop_complete: fd=%0d latch=%0d pd=%0d to=%0d want 1,7,8,0",
                     n_fd, n_latch, n_pd, timed_out);
        end
        errs = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (oe || load_req || latch || frame_done) errs++;
        end
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL drop_idle: active cycles=%0d want 0", errs);
        end
    endtask

    task automatic test_mid_reset();
        int k;
        base_len = 8'd0;
        load_ack = 1'b1;
        apply_reset();
        enable = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!oe && k < 200);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (oe !== 1'b0 || load_req !== 1'b0 || row !== 1'b0 ||
            select !== 2'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: oe=%b req=%b row=%0d sel=%0d want 0,0,0,0",
                     oe, load_req, row, select);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (load_req !== 1'b1 || req_row !== 1'b0 || req_bit !== 2'd3) begin
            n_fail++;
            $display("FAIL midrst_first_req: req=%b row=%0d bit=%0d want 1,0,3",
                     load_req, req_row, req_bit);
        end
        enable = 1'b0;
    endtask

`ifdef DISPLAY_BCM_DIM_EN
    task automatic test_dim();
        base_len = 8'd0;
        dim = 3'd2;
        load_ack = 1'b1;
        apply_reset();
        enable = 1'b1;
        measure_frame(500, -1, 8'd0);
        measure_frame(500, -1, 8'd0);
        n_tests++;
        if (timed_out || run_len[0] != 2 || run_len[1] != 1 ||
            run_len[3] != 1 || n_oe != 10) begin
            n_fail++;
            $display("FAIL dim_oe: r0=%0d r1=%0d r3=%0d oe=%0d want 2,1,1,10",
                     run_len[0], run_len[1], run_len[3], n_oe);
        end
        n_tests++;
        if (n_cyc != 47 || n_pd != 8) begin
            n_fail++;
            $display("FAIL dim_timing: cyc=%0d pd=%0d want 47,8", n_cyc, n_pd);
        end
        enable = 1'b0;
        dim = 3'd0;
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail = 0;
        rst = 1'b1;
        enable = 1'b0;
        base_len = 8'd0;
        dim = 3'd0;
        load_ack = 1'b0;
        test_reset();
        test_basic_frame();
        test_base_len();
        test_ack_wait();
        test_enable_drop();
        test_mid_reset();
`ifdef DISPLAY_BCM_DIM_EN
        test_dim();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
